mult_norm_seq: RTL and testbench
================================

Name: mult_norm_seq

Overview:
- Sequential, parametrised post-multiply normaliser.
- Accepts a raw double-width mantissa product and a biased exponent.
- Fixes a carry-out in one step with a right shift and exponent increment.
- Fixes leading zeros by left-shifting one bit per cycle, stopping at the hidden-one position or at exponent zero.
- Sits between the mantissa multiplier array and the rounding stage. Uses valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent width in bits.
- MANT_W, 23, stored mantissa width. Product width is P = 2*MANT_W+2.
- CNT_W, $clog2(2*MANT_W+2), width of the shift-count output.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- in_exp  in  EXP_W  biased exponent of the product.
- in_mant  in  P  raw product. Bit P-1 is the carry position; bit P-2 is the hidden-one position.
- out_valid  out  1  normalised result valid.
- out_ready  in  1  downstream accepts the result.
- out_exp  out  EXP_W  normalised exponent.
- out_mant  out  P  normalised mantissa.
- out_shift  out  CNT_W  number of left shifts applied.
- out_ovf  out  1  exponent reached all-ones.
- out_denorm  out  1  stopped at exponent 0 with hidden bit still clear.
- out_zero  out  1  input mantissa was zero.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n, clk). While rst_n is low, state = IDLE and all outputs are 0 except in_ready, which is 1.
- States: IDLE, NORM, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE: on in_valid && in_ready, register in_exp and in_mant, clear the shift counter and flags, go to NORM.
- NORM evaluates in this priority order, one decision per cycle:
  1. mant == 0: exp <= 0, zero <= 1, go to DONE.
  2. mant[P-1] == 1: mant <= mant >> 1 (logical), exp <= exp + 1, go to DONE.
     - If the incremented exponent equals all-ones, set ovf.
     - If the input exponent is already all-ones, hold it at all-ones (no wrap) and set ovf.
  3. mant[P-2] == 1: go to DONE, no change.
  4. exp == 0: set denorm, go to DONE.
  5. Otherwise: mant <= mant << 1, exp <= exp - 1, shift <= shift + 1, stay in NORM.
- Exponent never wraps below 0 or above all-ones.
- At most P-2 left shifts per operand, so shift never overflows CNT_W.
- DONE: hold every output stable until out_ready == 1, then go to IDLE.
  - in_valid is ignored in NORM and DONE.
  - No back-to-back acceptance in the DONE cycle.
- Latency, counted from the accept edge:
  - out_valid rises 2 cycles after accept plus 1 cycle per left shift.
  - Carry case, already-normalised case, zero case and immediate-denorm case: 2 cycles.
- Throughput: one operand per (latency + 1) cycles when out_ready is held high.
- Reset asserted mid-NORM or in DONE aborts immediately to IDLE and clears all outputs. The partial result is discarded.
- Outputs are registered directly from the working registers; there is no combinational path from in_* to out_*.

Optional Feature:
- Macro: MULT_NORM_LZC_EN.
- When defined, NORM performs the whole left normalisation in one cycle:
  - A leading-zero count of mant[P-2:0] gives lz.
  - Shift amount s = min(lz, exp).
  - mant <<= s, exp -= s, shift = s.
  - denorm is set if lz > exp.
  - Next state is DONE.
  - Every nonzero, non-carry case then has latency 2 cycles.
- Zero, carry, ovf and priority rules are unchanged.
- When not defined: iterative one-bit-per-cycle behaviour as above. No leading-zero counter logic is present.

Test Plan (EXP_W=8, MANT_W=23, P=48):
- Carry: in_mant=48'h8000_0000_0000, in_exp=8'h80 -> out_mant=48'h4000_0000_0000, out_exp=8'h81, out_shift=0, flags 0, out_valid 2 cycles after accept.
- Left shift: in_mant=48'h1000_0000_0000, in_exp=8'h10 -> out_mant=48'h4000_0000_0000, out_exp=8'h0E, out_shift=2, out_valid 4 cycles after accept (2 with MULT_NORM_LZC_EN).
- Denorm stop: in_mant=48'h1000_0000_0000, in_exp=8'h01 -> out_mant=48'h2000_0000_0000, out_exp=8'h00, out_shift=1, out_denorm=1.
- Zero and overflow:
  - in_mant=0, in_exp=8'h55 -> out_exp=0, out_mant=0, out_zero=1.
  - in_mant=48'h8000_0000_0000, in_exp=8'hFE -> out_exp=8'hFF, out_ovf=1.
  - in_mant=48'h8000_0000_0000, in_exp=8'hFF -> out_exp=8'hFF, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, pulsing in_valid -> outputs stable, in_ready=0, no new capture. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op: assert rst_n=0 during the 3rd NORM cycle of a 10-shift operand -> immediate IDLE, out_valid=0, in_ready=1. A new operand after release completes correctly.

Source files
------------

// File: rtl/mult_norm_seq_if.sv
// Handshake and data bundle between the mantissa multiplier, the normaliser and the rounder.
// The slave modport is the normaliser's view; master is the driving side.
interface mult_norm_seq_if #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23,
   parameter int CNT_W  = $clog2(2*MANT_W+2)
);
   localparam int P = 2*MANT_W+2;

   logic             in_valid;
   logic             in_ready;
   logic [EXP_W-1:0] in_exp;
   logic [P-1:0]     in_mant;
   logic             out_valid;
   logic             out_ready;
   logic [EXP_W-1:0] out_exp;
   logic [P-1:0]     out_mant;
   logic [CNT_W-1:0] out_shift;
   logic             out_ovf;
   logic             out_denorm;
   logic             out_zero;

   modport slave (
      input  in_valid, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_exp, out_mant, out_shift, out_ovf, out_denorm, out_zero
   );

   modport master (
      output in_valid, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_exp, out_mant, out_shift, out_ovf, out_denorm, out_zero
   );
endinterface

// File: rtl/mult_norm_seq.sv
// Post-multiply mantissa normaliser: carry fix-up in one step, leading zeros one bit per cycle.
// Define MULT_NORM_LZC_EN to do the whole left normalisation in one cycle via a leading-zero count.
module mult_norm_seq #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23,
   parameter int CNT_W  = $clog2(2*MANT_W+2)
) (
   input  logic           clk,
   input  logic           rst_n,
   mult_norm_seq_if.slave bus
);
   // state | meaning
   // IDLE  | waiting for an operand, in_ready high
   // NORM  | one normalisation decision per cycle
   // DONE  | result presented and held until out_ready

   localparam int P = 2*MANT_W+2;
   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t           state_q, state_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic [P-1:0]     mant_q, mant_d;
   logic [CNT_W-1:0] shift_q, shift_d;
   logic             ovf_q, ovf_d;
   logic             denorm_q, denorm_d;
   logic             zero_q, zero_d;

`ifdef MULT_NORM_LZC_EN
   logic [CNT_W-1:0]       lz;
   logic [EXP_W+CNT_W-1:0] lz_w, exp_w, sh_w;

   // Last set bit scanned wins, so lz counts from the hidden-one position downward.
   always_comb begin
      lz = '0;
      for (int i = 0; i < P-1; i++) begin
         if (mant_q[i]) lz = CNT_W'(P-2-i);
      end
   end

   assign lz_w = {{EXP_W{1'b0}}, lz};
   assign exp_w = {{CNT_W{1'b0}}, exp_q};
   assign sh_w = (lz_w < exp_w) ? lz_w : exp_w;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         exp_q    <= '0;
         mant_q   <= '0;
         shift_q  <= '0;
         ovf_q    <= 1'b0;
         denorm_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         shift_q  <= shift_d;
         ovf_q    <= ovf_d;
         denorm_q <= denorm_d;
         zero_q   <= zero_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      shift_d  = shift_q;
      ovf_d    = ovf_q;
      denorm_d = denorm_q;
      zero_d   = zero_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d  = NORM;
               exp_d    = bus.in_exp;
               mant_d   = bus.in_mant;
               shift_d  = '0;
               ovf_d    = 1'b0;
               denorm_d = 1'b0;
               zero_d   = 1'b0;
            end
         end
         NORM: begin
            state_d = DONE;
            if (mant_q == '0) begin
               exp_d  = '0;
               zero_d = 1'b1;
            end else if (mant_q[P-1]) begin
               // Exponent saturates at all-ones instead of wrapping.
               mant_d = mant_q >> 1;
               exp_d  = (exp_q == EXP_MAX) ? EXP_MAX : exp_q + EXP_W'(1);
               ovf_d  = (exp_q >= EXP_MAX - EXP_W'(1));
            end else if (mant_q[P-2]) begin
               state_d = DONE;
`ifdef MULT_NORM_LZC_EN
            end else begin
               mant_d   = mant_q << sh_w;
               exp_d    = exp_q - sh_w[EXP_W-1:0];
               shift_d  = sh_w[CNT_W-1:0];
               denorm_d = (lz_w > exp_w);
            end
`else
            end else if (exp_q == '0) begin
               denorm_d = 1'b1;
            end else begin
               state_d = NORM;
               mant_d  = mant_q << 1;
               exp_d   = exp_q - EXP_W'(1);
               shift_d = shift_q + CNT_W'(1);
            end
`endif
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.out_exp    = exp_q;
   assign bus.out_mant   = mant_q;
   assign bus.out_shift  = shift_q;
   assign bus.out_ovf    = ovf_q;
   assign bus.out_denorm = denorm_q;
   assign bus.out_zero   = zero_q;
endmodule

// File: tb/tb_mult_norm_seq.sv
// Randomised bench for mult_norm_seq against an arithmetic reference model of normalisation.
// Define MULT_NORM_LZC_EN here as for the RTL to expect single-cycle left normalisation.
module tb_mult_norm_seq;
   localparam int EXP_W  = 8;
   localparam int MANT_W = 23;
   localparam int P      = 2*MANT_W+2;
   localparam int CNT_W  = $clog2(P);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mult_norm_seq_if #(.EXP_W(EXP_W), .MANT_W(MANT_W), .CNT_W(CNT_W)) nbus ();

   mult_norm_seq #(.EXP_W(EXP_W), .MANT_W(MANT_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (nbus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Value-level view: find the leading one, shift it up to the hidden position
   // without letting the exponent go below zero.
   function automatic void ref_norm(input logic [P-1:0] m, input logic [EXP_W-1:0] e,
                                    output logic [P-1:0] rm, output logic [EXP_W-1:0] re,
                                    output int rs, output bit rovf, output bit rden,
                                    output bit rzero, output int rlat);
      int lz;
      int s;
      rm = m; re = e; rs = 0; rovf = 0; rden = 0; rzero = 0; rlat = 2;
      if (m == '0) begin
         rzero = 1;
         re    = '0;
      end else if (m[P-1]) begin
         rm   = m >> 1;
         re   = (e == 8'hFF) ? 8'hFF : e + 8'd1;
         rovf = (e >= 8'hFE);
      end else begin
         lz = 0;
         while (!m[P-2-lz]) lz++;
         s    = (lz < int'(e)) ? lz : int'(e);
         rm   = m << s;
         re   = e - 8'(s);
         rs   = s;
         rden = (lz > int'(e));
`ifdef MULT_NORM_LZC_EN
         rlat = 2;
`else
         rlat = 2 + s;
`endif
      end
   endfunction

   task automatic run_op(input logic [P-1:0] m, input logic [EXP_W-1:0] e, input int bp);
      logic [P-1:0]     rm;
      logic [EXP_W-1:0] re;
      int               rs, rlat, lat, w;
      bit               rovf, rden, rzero;
      ref_norm(m, e, rm, re, rs, rovf, rden, rzero, rlat);
      @(negedge clk);
      w = 0;
      while (!nbus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      nbus.in_valid  = 1'b1;
      nbus.in_exp    = e;
      nbus.in_mant   = m;
      nbus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      nbus.in_valid = 1'b0;
      lat = 1;
      while (!nbus.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(rlat));
      chk("mant", 64'(nbus.out_mant), 64'(rm));
      chk("exp", 64'(nbus.out_exp), 64'(re));
      chk("shift", 64'(nbus.out_shift), 64'(rs));
      chk("ovf", 64'(nbus.out_ovf), 64'(rovf));
      chk("denorm", 64'(nbus.out_denorm), 64'(rden));
      chk("zero", 64'(nbus.out_zero), 64'(rzero));
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         nbus.in_valid = 1'b1;
         nbus.in_mant  = P'({$urandom, $urandom});
         nbus.in_exp   = EXP_W'($urandom);
         @(posedge clk);
         #1;
         chk("bp_valid", 64'(nbus.out_valid), 64'd1);
         chk("bp_in_ready", 64'(nbus.in_ready), 64'd0);
         chk("bp_mant", 64'(nbus.out_mant), 64'(rm));
         chk("bp_exp", 64'(nbus.out_exp), 64'(re));
      end
      @(negedge clk);
      nbus.in_valid  = 1'b0;
      nbus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_valid", 64'(nbus.out_valid), 64'd0);
      chk("release_in_ready", 64'(nbus.in_ready), 64'd1);
      @(negedge clk);
      nbus.out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0]      r;
      logic [P-1:0]     m;
      logic [EXP_W-1:0] e;
      int               k;
      nbus.in_valid  = 1'b0;
      nbus.in_exp    = '0;
      nbus.in_mant   = '0;
      nbus.out_ready = 1'b0;
      rst_n          = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(nbus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(nbus.out_valid), 64'd0);
      chk("rst_mant", 64'(nbus.out_mant), 64'd0);
      chk("rst_exp", 64'(nbus.out_exp), 64'd0);
      chk("rst_flags", 64'({nbus.out_ovf, nbus.out_denorm, nbus.out_zero}), 64'd0);
      rst_n = 1'b1;

      run_op(48'h8000_0000_0000, 8'h80, 0);
      run_op(48'h1000_0000_0000, 8'h10, 5);
      run_op(48'h1000_0000_0000, 8'h01, 0);
      run_op(48'h0, 8'h55, 0);
      run_op(48'h8000_0000_0000, 8'hFE, 0);
      run_op(48'h8000_0000_0000, 8'hFF, 0);
      run_op(48'h4000_0000_0000, 8'h00, 0);
      run_op(48'h0000_0000_0001, 8'hC8, 0);

      // Abort a 10-shift operand during its third NORM cycle.
      @(negedge clk);
      nbus.in_valid = 1'b1;
      nbus.in_mant  = 48'h1 << 36;
      nbus.in_exp   = 8'h40;
      @(posedge clk);
      #1;
      nbus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 64'(nbus.out_valid), 64'd0);
      chk("abort_in_ready", 64'(nbus.in_ready), 64'd1);
      chk("abort_mant", 64'(nbus.out_mant), 64'd0);
      chk("abort_exp", 64'(nbus.out_exp), 64'd0);
      chk("abort_shift", 64'(nbus.out_shift), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(48'h1 << 36, 8'h40, 0);

      for (int n = 0; n < 60; n++) begin
         r = {$urandom, $urandom};
         m = r[P-1:0];
         case ($urandom_range(0, 9))
            0: m = '0;
            1: m[P-1] = 1'b1;
            default: begin
               k = $urandom_range(0, P-2);
               m = (m & ((48'h1 << k) - 48'h1)) | (48'h1 << k);
            end
         endcase
         case ($urandom_range(0, 3))
            0: e = EXP_W'($urandom_range(0, 15));
            1: e = EXP_W'($urandom_range(250, 255));
            default: e = EXP_W'($urandom);
         endcase
         run_op(m, e, $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
